// File: rtl/cuenta_pkg.sv
// Shared types for the parametrised ones/zeros counter.
// Holds the FSM state enum and the result-width helper.
package cuenta_pkg;

  typedef enum logic [1:0] {
    INICIO,
    CUENTA,
    FIN
  } estado_t;

  // Bits needed to hold any count from 0 to n inclusive.
  function automatic int cw_of(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/reg_desplaza.sv
// N-bit right shift register with parallel load, zero fill.
// Ports: clk, reset (async high), carga, desplaza, d[N-1:0] -> q.
module reg_desplaza #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         carga,
  input  logic         desplaza,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (carga) begin
      q <= d;
    end else if (desplaza) begin
      q <= {1'b0, q[N-1:1]};
    end
  end

endmodule

// File: rtl/cuenta_unos_param.sv
// Counts ones (modo=0) or zeros (modo=1) of Valor, exiting early.
// Ports: clk, reset, start, Valor, modo -> Cuenta, fin, ocupado.
module cuenta_unos_param
  import cuenta_pkg::*;
#(
  parameter int N  = 8,
  parameter int CW = cw_of(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [N-1:0]  Valor,
  input  logic          modo,
  output logic [CW-1:0] Cuenta,
  output logic          fin,
  output logic          ocupado
);

  estado_t       estado;
  estado_t       sig;
  logic [N-1:0]  q;
  logic [N-1:0]  d;
  logic [CW-1:0] a;
  logic [CW-1:0] suma;
  logic          qcero;

  logic CargaQ;
  logic DesplazaQ;
  logic ResetA;
  logic CargaA;

  // Counting zeros is counting ones of the complement.
  assign d     = modo ? ~Valor : Valor;
  assign qcero = (q == '0);
  assign suma  = a + {{(CW-1){1'b0}}, q[0]};

  reg_desplaza #(
    .N(N)
  ) u_q (
    .clk     (clk),
    .reset   (reset),
    .carga   (CargaQ),
    .desplaza(DesplazaQ),
    .d       (d),
    .q       (q)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a <= '0;
    end else if (ResetA) begin
      a <= '0;
    end else if (CargaA) begin
      a <= suma;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado <= INICIO;
    end else begin
      estado <= sig;
    end
  end

  always_comb begin
    sig       = estado;
    CargaQ    = 1'b0;
    DesplazaQ = 1'b0;
    ResetA    = 1'b0;
    CargaA    = 1'b0;
    unique case (estado)
      INICIO, FIN: begin
        if (start) begin
          CargaQ = 1'b1;
          ResetA = 1'b1;
          sig    = CUENTA;
        end
      end
      CUENTA: begin
        // Stop as soon as no relevant bits remain.
        if (qcero) begin
          sig = FIN;
        end else begin
          DesplazaQ = 1'b1;
          CargaA    = 1'b1;
        end
      end
      default: begin
        sig = INICIO;
      end
    endcase
  end

  assign Cuenta  = a;
  assign fin     = (estado == FIN);
  assign ocupado = (estado == CUENTA);

endmodule
